flip_candidate_sequencer: RTL and testbench
===========================================

// Module: flip_candidate_sequencer
// PURPOSE
//  Controller-side driver for the variable flip selector. Accepts one unsatisfied clause (NSAT variable ids),
//  fetches each variable's clause-broken/mask bits over a req/ack port, steps the selector through
//  wren = 01, 10, 11, then captures selected index + broken bits and emits one flip command downstream.
// PARAMETERS
//  NSAT                      3        literals per clause; only 3 supported (elaboration $error otherwise)
//  MAX_CLAUSES_PER_VARIABLE  20       MC, width of broken/mask vectors
//  VAR_BITS                  16       variable id width
// PORTS
//  clk                   in   1            clock
//  reset                 in   1            synchronous, active-low reset
//  clause_valid_i        in   1            clause offered
//  clause_ready_o        out  1            high only in IDLE
//  clause_vars_i         in   NSAT*VB      var id i at [i*VB +: VB]
//  clause_lits_valid_i   in   NSAT         per-literal valid mask
//  fetch_req_o           out  1            held until fetch_ack_i
//  fetch_var_o           out  VB           var id being fetched
//  fetch_ack_i           in   1            1-cycle pulse, data valid same cycle
//  fetch_broken_i        in   MC           clause-broken bits for fetch_var_o
//  fetch_mask_i          in   MC           valid-clause mask for fetch_var_o
//  clause_broken_o       out  MC           to selector clause_broken_i
//  mask_bits_o           out  MC           to selector mask_bits_i
//  break_values_valid_o  out  NSAT         to selector; latched clause_lits_valid_i
//  wren_o                out  2            00 idle, 01 slot0, 10 slot1, 11 select(slot2)
//  selected_i            in   2            selector selected_o
//  clause_broken_bits_i  in   MC           selector clause_broken_bits_o
//  flip_valid_o          out  1            flip command valid
//  flip_ready_i          in   1            downstream accepts
//  flip_var_o            out  VB           variable to flip
//  flip_broken_bits_o    out  MC           broken bits of chosen variable
//  no_candidate_o        out  1            1-cycle pulse: selector returned index >= NSAT
//  busy_o                out  1            state != IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE, idx 0; all outputs 0 except clause_ready_o=1.
//  States: IDLE -> FETCH -> WRITE -> (FETCH | CAPTURE) -> EMIT -> IDLE.
//  IDLE: clause_valid_i & clause_ready_o latches vars + lits mask, idx<=0, -> FETCH.
//  FETCH: if lits[idx]==0, no request; slot data forced 0, -> WRITE next cycle.
//   else fetch_req_o=1, fetch_var_o=var[idx]; on fetch_ack_i register broken/mask, -> WRITE.
//  WRITE (exactly 1 cycle): drive registered data on clause_broken_o/mask_bits_o;
//   wren_o = 01 (idx0), 10 (idx1), 11 (idx2). idx<2: idx++, -> FETCH. idx==2: -> CAPTURE.
//  wren_o is 00 in every non-WRITE cycle; never two non-idle wren cycles back to back.
//  CAPTURE (1 cycle, selector outputs now registered): selected_i < 3 -> latch flip_var_o=var[selected_i],
//   flip_broken_bits_o=clause_broken_bits_i, -> EMIT. selected_i==3 -> pulse no_candidate_o, -> IDLE.
//  EMIT: flip_valid_o=1, outputs stable until flip_ready_i; on handshake -> IDLE (clause_ready_o next cycle).
//  Latency, ack same cycle as req, all lits valid: accept t; WRITE t+2,t+4,t+6; CAPTURE t+7; flip_valid t+8.
//  fetch_ack_i outside FETCH is ignored (no state/data change).
//  Reset mid-operation: abandons clause, drops req same edge; no flip emitted; late ack ignored.
//  clause_valid_i while busy: not accepted, no effect.
// STRUCTURE
//  Shared package: WREN_IDLE=2'b00, WREN_SEL=2'b11, NO_SEL=2'b11, state enum, NSAT_BITS=$clog2(NSAT).
//  No sub-module; parent instantiates it beside the flip selector, wiring wren_o/selected_i directly.
// TESTING
//  1 vars {5,9,12}, lits 111, ack after 2 cycles, broken counts {3,1,2} -> wren 01,10,11 in order,
//    flip_var_o=9, flip_broken_bits_o = var9 bits.
//  2 lits 101 -> no fetch for var[1]; WRITE wren=10 with zero data; break_values_valid_o=101.
//  3 selector model forced to return 11 -> no_candidate_o 1 pulse, no flip_valid_o, clause_ready_o back high.
//  4 flip_ready_i low 5 cycles -> flip_valid_o/flip_var_o/bits stable; clause_valid_i ignored meanwhile.
//  5 reset low during FETCH of idx1 -> next cycle IDLE, fetch_req_o=0, wren_o=00; stray ack ignored.
//  6 zero-latency ack, back-to-back clauses -> flip_valid t+8 each; spurious ack in IDLE no effect.

Source files
------------

// File: rtl/flip_candidate_sequencer_pkg.sv
// Shared types and constants for the flip candidate sequencer.
// Selector write-enable codes, state encoding, slot index width.
package flip_candidate_sequencer_pkg;

    localparam int NSAT_DEF  = 3;
    localparam int NSAT_BITS = $clog2(NSAT_DEF);

    localparam logic [1:0] WREN_IDLE = 2'b00;
    localparam logic [1:0] WREN_SEL  = 2'b11;
    localparam logic [1:0] NO_SEL    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_CAPTURE,
        S_EMIT
    } state_t;

    // Slot k is written with code k+1; the last slot doubles as select.
    function automatic logic [1:0] wren_of(
        input logic [NSAT_BITS-1:0] idx
    );
        return 2'(idx) + 2'd1;
    endfunction

endpackage

// File: rtl/flip_candidate_sequencer_if.sv
// Flip command handshake between the sequencer and its consumer.
// The sequencer is master; the flip executor is slave.
interface flip_candidate_sequencer_if #(
    parameter int MC = 20,
    parameter int VB = 16
);

    logic          flip_valid_o;
    logic          flip_ready_i;
    logic [VB-1:0] flip_var_o;
    logic [MC-1:0] flip_broken_bits_o;

    modport master (
        output flip_valid_o,
        output flip_var_o,
        output flip_broken_bits_o,
        input  flip_ready_i
    );

    modport slave (
        input  flip_valid_o,
        input  flip_var_o,
        input  flip_broken_bits_o,
        output flip_ready_i
    );

endinterface

// File: rtl/flip_candidate_sequencer.sv
// Drives the variable flip selector for one unsatisfied clause:
// fetch per-variable bits, write three slots, capture, emit a flip.
module flip_candidate_sequencer
    import flip_candidate_sequencer_pkg::*;
#(
    parameter int NSAT                     = 3,
    parameter int MAX_CLAUSES_PER_VARIABLE = 20,
    parameter int VAR_BITS                 = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clause_valid_i,
    output logic                     clause_ready_o,
    input  logic [NSAT*VAR_BITS-1:0] clause_vars_i,
    input  logic [NSAT-1:0]          clause_lits_valid_i,
    output logic                     fetch_req_o,
    output logic [VAR_BITS-1:0]      fetch_var_o,
    input  logic                     fetch_ack_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] fetch_broken_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] fetch_mask_i,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
    output logic [NSAT-1:0]          break_values_valid_o,
    output logic [1:0]               wren_o,
    input  logic [1:0]               selected_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_bits_i,
    flip_candidate_sequencer_if.master flip,
    output logic                     no_candidate_o,
    output logic                     busy_o
);

    localparam int MC = MAX_CLAUSES_PER_VARIABLE;
    localparam int VB = VAR_BITS;
    localparam logic [NSAT_BITS-1:0] LAST_IDX =
        NSAT_BITS'(NSAT_DEF - 1);

    if (NSAT != NSAT_DEF) begin : g_bad_nsat
        $error("flip_candidate_sequencer: only NSAT=3 supported");
    end

    state_t                state_q;
    state_t                state_d;
    logic [NSAT*VB-1:0]    vars_q;
    logic [NSAT-1:0]       lits_q;
    logic [NSAT_BITS-1:0]  idx_q;
    logic [MC-1:0]         brk_q;
    logic [MC-1:0]         msk_q;
    logic [VB-1:0]         fvar_q;
    logic [MC-1:0]         fbits_q;
    logic [VB-1:0]         cur_var;
    logic                  cur_lit;

    assign cur_var = vars_q[idx_q*VB +: VB];
    assign cur_lit = lits_q[idx_q];

    assign break_values_valid_o    = lits_q;
    assign flip.flip_var_o         = fvar_q;
    assign flip.flip_broken_bits_o = fbits_q;
    assign busy_o                  = (state_q != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-state outputs.
    always_comb begin
        state_d           = state_q;
        clause_ready_o    = 1'b0;
        fetch_req_o       = 1'b0;
        fetch_var_o       = '0;
        clause_broken_o   = '0;
        mask_bits_o       = '0;
        wren_o            = WREN_IDLE;
        no_candidate_o    = 1'b0;
        flip.flip_valid_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                clause_ready_o = 1'b1;
                if (clause_valid_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!cur_lit) begin
                    state_d = S_WRITE;
                end else begin
                    fetch_req_o = 1'b1;
                    fetch_var_o = cur_var;
                    if (fetch_ack_i) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                clause_broken_o = brk_q;
                mask_bits_o     = msk_q;
                wren_o          = wren_of(idx_q);
                state_d = (idx_q == LAST_IDX) ? S_CAPTURE
                                              : S_FETCH;
            end
            S_CAPTURE: begin
                if (selected_i == NO_SEL) begin
                    no_candidate_o = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                flip.flip_valid_o = 1'b1;
                if (flip.flip_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Clause latch, slot data, slot index and flip command registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vars_q  <= '0;
            lits_q  <= '0;
            idx_q   <= '0;
            brk_q   <= '0;
            msk_q   <= '0;
            fvar_q  <= '0;
            fbits_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (clause_valid_i) begin
                        vars_q <= clause_vars_i;
                        lits_q <= clause_lits_valid_i;
                        idx_q  <= '0;
                    end
                end
                S_FETCH: begin
                    if (!cur_lit) begin
                        brk_q <= '0;
                        msk_q <= '0;
                    end else if (fetch_ack_i) begin
                        brk_q <= fetch_broken_i;
                        msk_q <= fetch_mask_i;
                    end
                end
                S_WRITE: begin
                    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                end
                S_CAPTURE: begin
                    if (selected_i != NO_SEL) begin
                        fvar_q  <= vars_q[selected_i*VB +: VB];
                        fbits_q <= clause_broken_bits_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flip_candidate_sequencer.sv
// Directed bench for flip_candidate_sequencer with a fetch
// responder and a min-broken-count selector model.
module tb_flip_candidate_sequencer;
    import flip_candidate_sequencer_pkg::*;

    localparam int NSAT = 3;
    localparam int MC   = 20;
    localparam int VB   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clause_valid_i = 1'b0;
    logic              clause_ready_o;
    logic [NSAT*VB-1:0] clause_vars_i = '0;
    logic [NSAT-1:0]   clause_lits_valid_i = '0;
    logic              fetch_req_o;
    logic [VB-1:0]     fetch_var_o;
    logic              fetch_ack_i;
    logic [MC-1:0]     fetch_broken_i;
    logic [MC-1:0]     fetch_mask_i;
    logic [MC-1:0]     clause_broken_o;
    logic [MC-1:0]     mask_bits_o;
    logic [NSAT-1:0]   break_values_valid_o;
    logic [1:0]        wren_o;
    logic [1:0]        selected_i;
    logic [MC-1:0]     clause_broken_bits_i;
    logic              no_candidate_o;
    logic              busy_o;

    flip_candidate_sequencer_if #(.MC(MC), .VB(VB)) fi ();

    flip_candidate_sequencer #(
        .NSAT(NSAT),
        .MAX_CLAUSES_PER_VARIABLE(MC),
        .VAR_BITS(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clause_valid_i(clause_valid_i),
        .clause_ready_o(clause_ready_o),
        .clause_vars_i(clause_vars_i),
        .clause_lits_valid_i(clause_lits_valid_i),
        .fetch_req_o(fetch_req_o),
        .fetch_var_o(fetch_var_o),
        .fetch_ack_i(fetch_ack_i),
        .fetch_broken_i(fetch_broken_i),
        .fetch_mask_i(fetch_mask_i),
        .clause_broken_o(clause_broken_o),
        .mask_bits_o(mask_bits_o),
        .break_values_valid_o(break_values_valid_o),
        .wren_o(wren_o),
        .selected_i(selected_i),
        .clause_broken_bits_i(clause_broken_bits_i),
        .flip(fi),
        .no_candidate_o(no_candidate_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [MC-1:0] broken_of(input logic [VB-1:0] v);
        case (v)
            16'd5:   return 20'h00007;
            16'd9:   return 20'h00100;
            16'd12:  return 20'h30000;
            16'd7:   return 20'h0000F;
            16'd3:   return 20'h00001;
            16'd20:  return 20'h00003;
            default: return 20'h00000;
        endcase
    endfunction

    function automatic logic [MC-1:0] mask_of(input logic [VB-1:0] v);
        return {v, 4'h5};
    endfunction

    // Fetch responder
    int         ack_delay = 0;
    bit         stray_ack = 1'b0;
    logic [VB-1:0] fetched[$];

    initial begin
        int cnt;
        cnt = 0;
        fetch_ack_i    = 1'b0;
        fetch_broken_i = '0;
        fetch_mask_i   = '0;
        forever begin
            @(negedge clk);
            fetch_ack_i    = 1'b0;
            fetch_broken_i = '0;
            fetch_mask_i   = '0;
            if (stray_ack) begin
                fetch_ack_i    = 1'b1;
                fetch_broken_i = '1;
                fetch_mask_i   = '1;
            end else if (fetch_req_o) begin
                if (cnt == ack_delay) begin
                    fetch_ack_i    = 1'b1;
                    fetch_broken_i = broken_of(fetch_var_o);
                    fetch_mask_i   = mask_of(fetch_var_o);
                    fetched.push_back(fetch_var_o);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Selector model: lowest broken count among valid slots
    bit            force_sel = 1'b0;
    logic [MC-1:0] slot_b [3];
    logic [MC-1:0] slot_m [3];
    logic [1:0]    wren_log[$];
    int            wren_cyc[$];
    int            nc_cnt = 0;
    int            fv_cnt = 0;

    function automatic logic [1:0] pick(
        input logic [MC-1:0] b0,
        input logic [MC-1:0] b1,
        input logic [MC-1:0] b2,
        input logic [2:0]    v
    );
        logic [MC-1:0] b [3];
        int best;
        logic [1:0] s;
        b[0] = b0; b[1] = b1; b[2] = b2;
        best = MC + 1;
        s = 2'b11;
        for (int i = 0; i < 3; i++) begin
            if (v[i] && $countones(b[i]) < best) begin
                best = $countones(b[i]);
                s = 2'(i);
            end
        end
        return s;
    endfunction

    initial begin
        int k;
        logic [1:0] s;
        selected_i = 2'b00;
        clause_broken_bits_i = '0;
        for (int i = 0; i < 3; i++) begin
            slot_b[i] = '0;
            slot_m[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (wren_o != WREN_IDLE) begin
                k = int'(wren_o) - 1;
                slot_b[k] = clause_broken_o;
                slot_m[k] = mask_bits_o;
                wren_log.push_back(wren_o);
                wren_cyc.push_back(cyc);
                if (wren_o == WREN_SEL) begin
                    s = pick(slot_b[0], slot_b[1], slot_b[2],
                             break_values_valid_o);
                    selected_i = force_sel ? NO_SEL : s;
                    clause_broken_bits_i =
                        (s == NO_SEL) ? '0 : slot_b[s];
                end
            end
            nc_cnt += int'(no_candidate_o);
            fv_cnt += int'(fi.flip_valid_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic drive_clause(
        input logic [VB-1:0] v0,
        input logic [VB-1:0] v1,
        input logic [VB-1:0] v2,
        input logic [2:0]    l,
        output int           t
    );
        int n;
        @(negedge clk);
        clause_vars_i       = {v2, v1, v0};
        clause_lits_valid_i = l;
        clause_valid_i      = 1'b1;
        n = 0;
        while (!clause_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        @(negedge clk);
        clause_valid_i = 1'b0;
    endtask

    task automatic wait_flip(output int tf, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (fi.flip_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tf = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fi.flip_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (clause_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", clause_ready_o);
        end
        checks++;
        if ({busy_o, fetch_req_o, wren_o, no_candidate_o,
             fi.flip_valid_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {busy_o, fetch_req_o, wren_o, no_candidate_o,
                      fi.flip_valid_o});
        end
        checks++;
        if ({fetch_var_o, clause_broken_o, mask_bits_o,
             break_values_valid_o, fi.flip_var_o,
             fi.flip_broken_bits_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: nonzero data outputs");
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int t, tf;
        bit ok;
        ack_delay = 2;
        wren_log.delete();
        wren_cyc.delete();
        fetched.delete();
        drive_clause(16'd5, 16'd9, 16'd12, 3'b111, t);
        wait_flip(tf, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: got no flip want flip");
        end
        checks++;
        if (tf !== t + 14) begin
            errors++;
            $display("FAIL basic_latency: got %0d want %0d",
                     tf - t, 14);
        end
        checks++;
        if (wren_log.size() != 3 || wren_log[0] !== 2'b01 ||
            wren_log[1] !== 2'b10 || wren_log[2] !== 2'b11) begin
            errors++;
            $display("FAIL basic_wren_seq: got %p want 1,2,3",
                     wren_log);
        end else begin
            checks++;
            if (wren_cyc[1] - wren_cyc[0] < 2 ||
                wren_cyc[2] - wren_cyc[1] < 2) begin
                errors++;
                $display("FAIL basic_wren_gap: got %p", wren_cyc);
            end
        end
        checks++;
        if (slot_m[0] !== mask_of(16'd5)) begin
            errors++;
            $display("FAIL basic_mask0: got %h want %h",
                     slot_m[0], mask_of(16'd5));
        end
        checks++;
        if (fi.flip_var_o !== 16'd9 ||
            fi.flip_broken_bits_o !== 20'h00100) begin
            errors++;
            $display("FAIL basic_flip: got %0d/%h want 9/00100",
                     fi.flip_var_o, fi.flip_broken_bits_o);
        end
        checks++;
        if (fetched.size() != 3) begin
            errors++;
            $display("FAIL basic_fetches: got %0d want 3",
                     fetched.size());
        end
        @(negedge clk);
        checks++;
        if (clause_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got rdy=%b busy=%b want 1/0",
                     clause_ready_o, busy_o);
        end
    endtask

    task automatic test_lits_masked();
        int t, tf;
        bit ok;
        ack_delay = 1;
        wren_log.delete();
        fetched.delete();
        drive_clause(16'd5, 16'd9, 16'd12, 3'b101, t);
        wait_flip(tf, ok);
        checks++;
        if (!ok || fetched.size() != 2 || fetched[0] !== 16'd5 ||
            fetched[1] !== 16'd12) begin
            errors++;
            $display("FAIL masked_fetch: got %p want 5,12", fetched);
        end
        checks++;
        if (wren_log.size() != 3 || wren_log[1] !== 2'b10 ||
            slot_b[1] !== '0 || slot_m[1] !== '0) begin
            errors++;
            $display("FAIL masked_slot1: got %h/%h want 0/0",
                     slot_b[1], slot_m[1]);
        end
        checks++;
        if (break_values_valid_o !== 3'b101) begin
            errors++;
            $display("FAIL masked_bvv: got %b want 101",
                     break_values_valid_o);
        end
        checks++;
        if (fi.flip_var_o !== 16'd12 ||
            fi.flip_broken_bits_o !== 20'h30000) begin
            errors++;
            $display("FAIL masked_flip: got %0d/%h want 12/30000",
                     fi.flip_var_o, fi.flip_broken_bits_o);
        end
        @(negedge clk);
    endtask

    task automatic test_no_candidate();
        int t;
        ack_delay = 0;
        force_sel = 1'b1;
        nc_cnt = 0;
        fv_cnt = 0;
        drive_clause(16'd7, 16'd3, 16'd20, 3'b111, t);
        repeat (15) @(negedge clk);
        checks++;
        if (nc_cnt != 1) begin
            errors++;
            $display("FAIL nocand_pulse: got %0d want 1", nc_cnt);
        end
        checks++;
        if (fv_cnt != 0) begin
            errors++;
            $display("FAIL nocand_flip: got %0d want 0", fv_cnt);
        end
        checks++;
        if (clause_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL nocand_idle: got rdy=%b busy=%b want 1/0",
                     clause_ready_o, busy_o);
        end
        force_sel = 1'b0;
    endtask

    task automatic test_backpressure();
        int t, tf;
        bit ok;
        ack_delay = 0;
        fi.flip_ready_i = 1'b0;
        drive_clause(16'd20, 16'd7, 16'd5, 3'b111, t);
        wait_flip(tf, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: got no flip want flip");
        end
        clause_vars_i       = {16'd1, 16'd2, 16'd3};
        clause_lits_valid_i = 3'b011;
        clause_valid_i      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (fi.flip_valid_o !== 1'b1 ||
                fi.flip_var_o !== 16'd20 ||
                fi.flip_broken_bits_o !== 20'h00003 ||
                clause_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b var=%0d b=%h r=%b",
                         i, fi.flip_valid_o, fi.flip_var_o,
                         fi.flip_broken_bits_o, clause_ready_o);
            end
            @(negedge clk);
        end
        clause_valid_i  = 1'b0;
        fi.flip_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (fi.flip_valid_o !== 1'b0 || clause_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got v=%b r=%b want 0/1",
                     fi.flip_valid_o, clause_ready_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || break_values_valid_o !== 3'b111) begin
            errors++;
            $display("FAIL bp_ignored: got busy=%b bvv=%b want 0/111",
                     busy_o, break_values_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int t, n;
        ack_delay = 3;
        drive_clause(16'd5, 16'd9, 16'd12, 3'b111, t);
        n = 0;
        while (!(fetch_req_o && fetch_var_o == 16'd9) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL rstmid_reach: got timeout want fetch idx1");
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || fetch_req_o !== 1'b0 ||
            wren_o !== 2'b00 || clause_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle: got b=%b q=%b w=%b r=%b",
                     busy_o, fetch_req_o, wren_o, clause_ready_o);
        end
        reset = 1'b1;
        fv_cnt = 0;
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || fv_cnt != 0 ||
            break_values_valid_o !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_stray: got b=%b fv=%0d bvv=%b",
                     busy_o, fv_cnt, break_values_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int t1, tf1, t2, tf2;
        bit ok1, ok2;
        ack_delay = 0;
        fi.flip_ready_i = 1'b1;
        @(negedge clk);
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || clause_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stray: got busy=%b want 0", busy_o);
        end
        drive_clause(16'd7, 16'd3, 16'd20, 3'b111, t1);
        wait_flip(tf1, ok1);
        checks++;
        if (!ok1 || tf1 !== t1 + 8) begin
            errors++;
            $display("FAIL b2b_lat_a: got %0d want 8", tf1 - t1);
        end
        checks++;
        if (fi.flip_var_o !== 16'd3 ||
            fi.flip_broken_bits_o !== 20'h00001) begin
            errors++;
            $display("FAIL b2b_flip_a: got %0d/%h want 3/00001",
                     fi.flip_var_o, fi.flip_broken_bits_o);
        end
        drive_clause(16'd20, 16'd7, 16'd5, 3'b111, t2);
        checks++;
        if (t2 !== tf1 + 1) begin
            errors++;
            $display("FAIL b2b_accept: got %0d want %0d", t2, tf1 + 1);
        end
        wait_flip(tf2, ok2);
        checks++;
        if (!ok2 || tf2 !== t2 + 8) begin
            errors++;
            $display("FAIL b2b_lat_b: got %0d want 8", tf2 - t2);
        end
        checks++;
        if (fi.flip_var_o !== 16'd20 ||
            fi.flip_broken_bits_o !== 20'h00003) begin
            errors++;
            $display("FAIL b2b_flip_b: got %0d/%h want 20/00003",
                     fi.flip_var_o, fi.flip_broken_bits_o);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lits_masked();
        test_no_candidate();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
